// File: rtl/cksum_arbiter.sv
// -----------------------------------------------------------------------------
// cksum_arbiter
//
// Shares one checksum engine among N_REQ requesters with round-robin
// arbitration. In IDLE the winner's field window (start/len) is latched and
// handed to the engine together with a one-cycle start pulse. The arbiter then
// waits for the engine's ready level and returns the 16-bit result to the
// winner with a one-cycle done pulse. Header bytes are not routed here; all
// requesters and the engine address the same shared header buffer.
//
// Optional build macro: CKSUM_ARB_TIMEOUT_EN
//   Defined   : WAIT has a watchdog of TIMEOUT_CYCLES cycles; on expiry the job
//               completes with err_o=1 and cksum_val_o=0.
//   Undefined : no watchdog, err_o is constant 0, WAIT waits indefinitely.
//
// Ports
//   clk                 clock
//   rst                 asynchronous reset, active-high
//   req_i               per-requester request level
//   field_start_i       per-requester field start address, requester i at
//                       [i*`ADDR_BUS +: `ADDR_BUS]
//   field_len_i         per-requester field length (bytes), requester i at
//                       [i*`DATA_BUS +: `DATA_BUS]
//   grant_o             one-hot grant, held from ISSUE through DONE
//   done_o              one-hot one-cycle completion pulse
//   cksum_val_o         result; valid with done_o, then holds
//   err_o               watchdog timeout flag, qualified by done_o
//   eng_start_o         engine start pulse (ISSUE only)
//   eng_field_start_o   latched field start to the engine
//   eng_field_len_o     latched field length to the engine
//   eng_cksum_val_i     engine result
//   eng_cksum_ready_i   engine ready level (cleared by the engine on start)
//
// States
//   IDLE  | no job; arbitrate among req_i
//   ISSUE | one cycle with eng_start_o high
//   WAIT  | waiting for engine ready (or watchdog)
//   DONE  | done_o pulse to the granted requester
// -----------------------------------------------------------------------------

`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef DATA_BUS
`define DATA_BUS 16
`endif
`ifndef HALF_BUS
`define HALF_BUS 16
`endif

module cksum_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ*`ADDR_BUS-1:0]   field_start_i,
  input  logic [N_REQ*`DATA_BUS-1:0]   field_len_i,
  output logic [N_REQ-1:0]             grant_o,
  output logic [N_REQ-1:0]             done_o,
  output logic [`HALF_BUS-1:0]         cksum_val_o,
  output logic                         err_o,
  output logic                         eng_start_o,
  output logic [`ADDR_BUS-1:0]         eng_field_start_o,
  output logic [`DATA_BUS-1:0]         eng_field_len_o,
  input  logic [`HALF_BUS-1:0]         eng_cksum_val_i,
  input  logic                         eng_cksum_ready_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q,  state_d;
  logic [N_REQ-1:0]       grant_q,  grant_d;
  logic [N_REQ-1:0]       done_q,   done_d;
  logic [PTR_W-1:0]       ptr_q,    ptr_d;
  logic [PTR_W-1:0]       gidx_q,   gidx_d;
  logic [`HALF_BUS-1:0]   cksum_q,  cksum_d;
  logic                   start_q,  start_d;
  logic [`ADDR_BUS-1:0]   fstart_q, fstart_d;
  logic [`DATA_BUS-1:0]   flen_q,   flen_d;

  logic                   pick_vld;
  logic [PTR_W-1:0]       pick_idx;

`ifdef CKSUM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]       tmo_cnt_q;
  logic                   err_q, err_d;
  logic                   tmo_hit;
`endif

  // Round-robin pick: the scan runs from the far end back toward ptr+1 so
  // the last hit, which is the one kept, is the first set bit after ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_i[(int'(ptr_q) + i) % N_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

`ifdef CKSUM_ARB_TIMEOUT_EN
  // The count holds the number of WAIT cycles already spent without ready;
  // the limit is reached at the edge that would bring it to TIMEOUT_CYCLES.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_WAIT) && !eng_cksum_ready_i) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    cksum_d  = cksum_q;
    start_d  = 1'b0;
    fstart_d = fstart_q;
    flen_d   = flen_q;
`ifdef CKSUM_ARB_TIMEOUT_EN
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          fstart_d          = field_start_i[int'(pick_idx)*`ADDR_BUS +: `ADDR_BUS];
          flen_d            = field_len_i[int'(pick_idx)*`DATA_BUS +: `DATA_BUS];
          start_d           = 1'b1;
          state_d           = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Ready wins over a watchdog expiry in the same cycle.
        if (eng_cksum_ready_i) begin
          cksum_d = eng_cksum_val_i;
          done_d  = grant_q;
          ptr_d   = gidx_q;
          state_d = S_DONE;
`ifdef CKSUM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          cksum_d = '0;
          done_d  = grant_q;
          ptr_d   = gidx_q;
          err_d   = 1'b1;
          state_d = S_DONE;
`endif
        end
      end

      S_DONE: begin
        grant_d = '0;
`ifdef CKSUM_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        state_d = S_IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      ptr_q    <= PTR_W'(N_REQ - 1);
      gidx_q   <= '0;
      cksum_q  <= '0;
      start_q  <= 1'b0;
      fstart_q <= '0;
      flen_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      cksum_q  <= cksum_d;
      start_q  <= start_d;
      fstart_q <= fstart_d;
      flen_q   <= flen_d;
    end
  end

`ifdef CKSUM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign grant_o           = grant_q;
  assign done_o            = done_q;
  assign cksum_val_o       = cksum_q;
  assign eng_start_o       = start_q;
  assign eng_field_start_o = fstart_q;
  assign eng_field_len_o   = flen_q;

endmodule

// File: tb/tb_cksum_arbiter.sv
`timescale 1ns/1ps

`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef DATA_BUS
`define DATA_BUS 16
`endif
`ifndef HALF_BUS
`define HALF_BUS 16
`endif

module tb_cksum_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int AW  = `ADDR_BUS;
  localparam int DW  = `DATA_BUS;
  localparam int HW  = `HALF_BUS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_i = '0;
  logic [N*AW-1:0]   field_start_i = '0;
  logic [N*DW-1:0]   field_len_i = '0;
  logic [N-1:0]      grant_o;
  logic [N-1:0]      done_o;
  logic [HW-1:0]     cksum_val_o;
  logic              err_o;
  logic              eng_start_o;
  logic [AW-1:0]     eng_field_start_o;
  logic [DW-1:0]     eng_field_len_o;
  logic [HW-1:0]     eng_cksum_val_i;
  logic              eng_cksum_ready_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always #5 clk = ~clk;

  cksum_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_i             (req_i),
    .field_start_i     (field_start_i),
    .field_len_i       (field_len_i),
    .grant_o           (grant_o),
    .done_o            (done_o),
    .cksum_val_o       (cksum_val_o),
    .err_o             (err_o),
    .eng_start_o       (eng_start_o),
    .eng_field_start_o (eng_field_start_o),
    .eng_field_len_o   (eng_field_len_o),
    .eng_cksum_val_i   (eng_cksum_val_i),
    .eng_cksum_ready_i (eng_cksum_ready_i)
  );

  // Engine model: shared header buffer, ones-complement checksum, ready
  // raised so that done lands ceil(len/2)+4 cycles after the start cycle.
  logic [7:0] hdr [0:255];
  int         eng_cnt;
  logic       eng_hold;

  function automatic logic [15:0] ones_cksum(input int s, input int l);
    logic [31:0] acc;
    logic [15:0] w;
    acc = '0;
    for (int k = 0; k < l; k += 2) begin
      w = {hdr[(s + k) & 255], (k + 1 < l) ? hdr[(s + k + 1) & 255] : 8'h00};
      acc = acc + {16'h0, w};
    end
    while (acc[31:16] != 16'h0) acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    return ~acc[15:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt           <= 0;
      eng_cksum_ready_i <= 1'b0;
      eng_cksum_val_i   <= '0;
    end else if (eng_start_o) begin
      eng_cksum_val_i   <= ones_cksum(int'(eng_field_start_o), int'(eng_field_len_o));
      eng_cnt           <= (int'(eng_field_len_o) + 1) / 2 + 2;
      eng_cksum_ready_i <= 1'b0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hold) eng_cksum_ready_i <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_field(input int i, input int s, input int l);
    field_start_i[i*AW +: AW] = AW'(s);
    field_len_i[i*DW +: DW]   = DW'(l);
  endtask

  // Waits for a start pulse, then for done; returns what was observed.
  task automatic run_job(output bit ok, output int s_cyc, output int lat,
                         output logic [N-1:0] g, output logic [N-1:0] d,
                         output logic [HW-1:0] cv, output logic er,
                         output logic [AW-1:0] fs, output logic [DW-1:0] fl,
                         output int nstart);
    int t;
    ok = 1'b1; s_cyc = 0; lat = 0; g = '0; d = '0; cv = '0; er = 1'b0;
    fs = '0; fl = '0; nstart = 0;
    t = 0;
    while (eng_start_o !== 1'b1 && t < 20) begin tick(); t++; end
    if (eng_start_o !== 1'b1) begin ok = 1'b0; return; end
    s_cyc = cyc; g = grant_o; fs = eng_field_start_o; fl = eng_field_len_o;
    nstart = 1;
    t = 0;
    do begin
      tick(); t++;
      if (eng_start_o === 1'b1) nstart++;
    end while (done_o === '0 && t < 200);
    if (done_o === '0) ok = 1'b0;
    lat = cyc - s_cyc; d = done_o; cv = cksum_val_o; er = err_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({grant_o, done_o, eng_start_o, err_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: grant=%b done=%b start=%b err=%b, want all 0",
               grant_o, done_o, eng_start_o, err_o);
    end
    tests_run++;
    if ({cksum_val_o, eng_field_start_o, eng_field_len_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: cksum=%h fstart=%h flen=%h, want 0",
               cksum_val_o, eng_field_start_o, eng_field_len_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit ok; int s, lat, ns, last_done;
    logic [N-1:0] g, d; logic [HW-1:0] cv; logic er;
    logic [AW-1:0] fs; logic [DW-1:0] fl;
    for (int i = 0; i < N; i++) set_field(i, 100 + 10 * i, 2 * i + 2);
    req_i = 4'b1111;
    last_done = 0;
    for (int j = 0; j < 5; j++) begin
      if (j == 4) req_i = 4'b1111;
      run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
      tests_run++;
      if (!ok || g !== exp_g[j] || d !== exp_g[j] || ns != 1) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: ok=%0d grant=%b done=%b starts=%0d, want grant=done=%b starts=1",
                 j, ok, g, d, ns, exp_g[j]);
      end
      begin
        int idx, exp_lat;
        idx = (j == 4) ? 0 : j;
        exp_lat = idx + 5;
        tests_run++;
        if (lat != exp_lat || fs !== AW'(100 + 10 * idx) || fl !== DW'(2 * idx + 2)) begin
          tests_failed++;
          $display("FAIL rr_job[%0d]: lat=%0d fstart=%0d flen=%0d, want %0d %0d %0d",
                   j, lat, fs, fl, exp_lat, 100 + 10 * idx, 2 * idx + 2);
        end
      end
      if (j > 0) begin
        tests_run++;
        if (s - last_done != 2) begin
          tests_failed++;
          $display("FAIL rr_gap[%0d]: start-to-prev-done=%0d, want 2", j, s - last_done);
        end
      end
      last_done = cyc;
      if (j == 4) req_i = '0;
      tick();
      tests_run++;
      if (done_o !== '0 || grant_o !== '0 || eng_start_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_idle[%0d]: done=%b grant=%b start=%b, want 0", j, done_o, grant_o, eng_start_o);
      end
    end
    tick();
  endtask

  task automatic test_single;
    bit ok; int s, lat, ns;
    logic [N-1:0] g, d; logic [HW-1:0] cv; logic er;
    logic [AW-1:0] fs; logic [DW-1:0] fl;
    set_field(0, 14, 20);
    req_i = 4'b0001;
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    req_i = '0;
    tests_run++;
    if (!ok || g !== 4'b0001 || d !== 4'b0001 || ns != 1) begin
      tests_failed++;
      $display("FAIL single_grant: ok=%0d grant=%b done=%b starts=%0d, want 0001 0001 1", ok, g, d, ns);
    end
    tests_run++;
    if (lat != 14 || cv !== 16'h0000 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result: lat=%0d cksum=%h err=%b, want 14 0000 0", lat, cv, er);
    end
    tests_run++;
    if (fs !== AW'(14) || fl !== DW'(20)) begin
      tests_failed++;
      $display("FAIL single_fields: fstart=%0d flen=%0d, want 14 20", fs, fl);
    end
    tick();
    tests_run++;
    if (done_o !== '0 || cksum_val_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_after: done=%b cksum=%h, want 0000 0000 (held)", done_o, cksum_val_o);
    end
    tick();
  endtask

  task automatic test_late_request;
    bit ok; int s, lat, ns, t;
    logic [N-1:0] g, d; logic [HW-1:0] cv; logic er;
    logic [AW-1:0] fs; logic [DW-1:0] fl;
    set_field(1, 30, 6);
    set_field(2, 14, 20);
    req_i = 4'b0100;
    t = 0;
    while (eng_start_o !== 1'b1 && t < 20) begin tick(); t++; end
    tests_run++;
    if (eng_start_o !== 1'b1 || grant_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL late_first_grant: start=%b grant=%b, want 1 0100", eng_start_o, grant_o);
    end
    tick();
    tick();
    req_i = 4'b0110;
    set_field(2, 0, 2);
    t = 0;
    while (done_o === '0 && t < 100) begin tick(); t++; end
    tests_run++;
    if (done_o !== 4'b0100 || cksum_val_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL late_first_done: done=%b cksum=%h, want 0100 0000", done_o, cksum_val_o);
    end
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    tests_run++;
    if (!ok || g !== 4'b0010 || d !== 4'b0010 || lat != 7) begin
      tests_failed++;
      $display("FAIL late_second: ok=%0d grant=%b done=%b lat=%0d, want 0010 0010 7", ok, g, d, lat);
    end
    req_i = 4'b0100;
    set_field(2, 14, 20);
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    req_i = '0;
    tests_run++;
    if (!ok || g !== 4'b0100 || d !== 4'b0100 || cv !== 16'h0000) begin
      tests_failed++;
      $display("FAIL late_third: ok=%0d grant=%b done=%b cksum=%h, want 0100 0100 0000", ok, g, d, cv);
    end
    tick(); tick();
  endtask

  task automatic test_zero_len;
    bit ok; int s, lat, ns;
    logic [N-1:0] g, d; logic [HW-1:0] cv; logic er;
    logic [AW-1:0] fs; logic [DW-1:0] fl;
    set_field(2, 40, 0);
    req_i = 4'b0100;
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    req_i = '0;
    tests_run++;
    if (!ok || d !== 4'b0100 || lat != 4 || cv !== 16'hFFFF || fl !== DW'(0)) begin
      tests_failed++;
      $display("FAIL zero_len: ok=%0d done=%b lat=%0d cksum=%h flen=%0d, want 0100 4 ffff 0",
               ok, d, lat, cv, fl);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_job;
    bit ok; int s, lat, ns, t;
    logic [N-1:0] g, d; logic [HW-1:0] cv; logic er;
    logic [AW-1:0] fs; logic [DW-1:0] fl;
    set_field(0, 0, 40);
    req_i = 4'b0001;
    t = 0;
    while (eng_start_o !== 1'b1 && t < 20) begin tick(); t++; end
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (grant_o !== '0 || done_o !== '0 || eng_start_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: grant=%b done=%b start=%b, want 0", grant_o, done_o, eng_start_o);
    end
    req_i = 4'b1000;
    set_field(3, 14, 20);
    tick();
    rst = 1'b0;
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    req_i = '0;
    tests_run++;
    if (!ok || g !== 4'b1000 || d !== 4'b1000 || lat != 14 || cv !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_mid_after: ok=%0d grant=%b done=%b lat=%0d cksum=%h, want 1000 1000 14 0000",
               ok, g, d, lat, cv);
    end
    tick(); tick();
  endtask

`ifdef CKSUM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok; int s, lat, ns;
    logic [N-1:0] g, d; logic [HW-1:0] cv; logic er;
    logic [AW-1:0] fs; logic [DW-1:0] fl;
    eng_hold = 1'b1;
    set_field(0, 14, 20);
    req_i = 4'b0001;
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    req_i = '0;
    tests_run++;
    if (!ok || d !== 4'b0001 || er !== 1'b1 || cv !== 16'h0000 || lat != TMO + 1) begin
      tests_failed++;
      $display("FAIL timeout: ok=%0d done=%b err=%b cksum=%h lat=%0d, want 0001 1 0000 %0d",
               ok, d, er, cv, lat, TMO + 1);
    end
    tick();
    eng_hold = 1'b0;
    set_field(1, 14, 20);
    req_i = 4'b0010;
    run_job(ok, s, lat, g, d, cv, er, fs, fl, ns);
    req_i = '0;
    tests_run++;
    if (!ok || d !== 4'b0010 || er !== 1'b0 || cv !== 16'h0000 || lat != 14) begin
      tests_failed++;
      $display("FAIL timeout_next: ok=%0d done=%b err=%b cksum=%h lat=%0d, want 0010 0 0000 14",
               ok, d, er, cv, lat);
    end
    tick(); tick();
  endtask
`endif

  initial begin
    byte unsigned ip [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                              8'h40, 8'h11, 8'hb8, 8'h61, 8'hc0, 8'ha8, 8'h00, 8'h01,
                              8'hc0, 8'ha8, 8'h00, 8'hc7};
    eng_hold = 1'b0;
    for (int i = 0; i < 256; i++) hdr[i] = 8'h00;
    for (int i = 0; i < 20; i++) hdr[14 + i] = ip[i];

    test_reset();
    test_round_robin();
    test_single();
    test_late_request();
    test_zero_len();
    test_reset_mid_job();
`ifdef CKSUM_ARB_TIMEOUT_EN
    test_timeout();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cksum_arbiter.md
Name: cksum_arbiter

Overview:
- Shares one cksum engine among N_REQ requesters, e.g. IPv4 header verify, rewrite-after-TTL-decrement and L4 pseudo-header stages.
- Arbitration is round-robin. The block latches the winner's field window, pulses the engine start, waits for the engine's ready, then returns the 16-bit result with a one-cycle done pulse to the winner.
- All requesters address the same shared pkt_hdr buffer. The arbiter muxes only the field start and length; it does not route header bytes.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only when CKSUM_ARB_TIMEOUT_EN is defined

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_i  in  N_REQ  per-requester request level
field_start_i  in  N_REQ x `ADDR_BUS  per-requester field start byte address
field_len_i  in  N_REQ x `DATA_BUS  per-requester field length in bytes
grant_o  out  N_REQ  one-hot grant; held from ISSUE through DONE
done_o  out  N_REQ  one-hot one-cycle completion pulse
cksum_val_o  out  `HALF_BUS  result; valid while any done_o bit is high, then holds its value
err_o  out  1  timeout flag; qualified by done_o
eng_start_o  out  1  engine start pulse
eng_field_start_o  out  `ADDR_BUS  latched field start to engine
eng_field_len_o  out  `DATA_BUS  latched field length to engine
eng_cksum_val_i  in  `HALF_BUS  engine result
eng_cksum_ready_i  in  1  engine ready level; cleared by the engine on start

Behaviour:
- Reset: all outputs are registered.
  - grant_o=0, done_o=0, eng_start_o=0, err_o=0.
  - cksum_val_o=0, eng_field_start_o=0, eng_field_len_o=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority. State = IDLE.
  - Asserting rst mid-operation aborts immediately with no done_o. The engine shares rst, so both restart clean.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req_i != 0, pick the first set bit scanning from pointer+1 upward, with wrap-around.
  - Register grant_o one-hot, latch that requester's field_start/field_len into the eng_field_* outputs, and set eng_start_o=1.
  - Go to ISSUE.
- ISSUE: lasts exactly one cycle with eng_start_o=1. Clear eng_start_o and go to WAIT.
  - The engine clears its ready on the same edge that accepts start, so a stale ready from the previous job is never observed.
- WAIT:
  - On the first cycle with eng_cksum_ready_i=1, register cksum_val_o <= eng_cksum_val_i and set done_o <= grant_o.
  - Set pointer to the granted index and go to DONE.
- DONE:
  - done_o is high for exactly this one cycle; grant_o is still high.
  - Next edge: clear grant_o and done_o, go to IDLE.
  - Minimum gap between consecutive jobs is one IDLE cycle.
- Latency: done_o is high exactly ceil(len/2)+4 cycles after the eng_start_o cycle.
- Requester rules:
  - req_i is a level; the requester holds it until it sees its done_o bit.
  - Dropping req_i after grant does not cancel the job; done_o still pulses.
  - Changing field_start_i or field_len_i after the grant has no effect.
  - A requester that keeps req_i high through DONE competes normally in the next IDLE. It wins again only if no other bit is set.
- Fairness: with all N_REQ requesting continuously, the grant order is 0,1,..,N_REQ-1,0,...
- Length handling: zero length is forwarded unchanged and the engine returns 0xFFFF. Odd lengths are forwarded unchanged; padding is the requester's responsibility.
- At most one outstanding engine job at any time. eng_start_o is never asserted outside ISSUE.

Optional Feature:
- Macro: CKSUM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle without ready.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err_o=1 and cksum_val_o=0, and pulse done_o to the granted requester.
  - err_o clears when leaving DONE.
  - A ready arriving in the same cycle the limit is reached takes priority: normal result, err_o=0.
- Not defined: no counter; err_o is tied to 0; WAIT waits indefinitely.

Test Plan:
- Single request: req_i=0001, start 14, len 20, 20-byte IPv4 header with a correct checksum -> grant_o=0001, one eng_start_o pulse, done_o=0001 exactly 14 cycles after start, cksum_val_o=0x0000.
- Round-robin: req_i=1111 held continuously -> grants in order 0,1,2,3,0; each done_o is one cycle wide; one IDLE cycle between consecutive DONE and ISSUE.
- Late-arriving request: req 2 active, req 1 raised during WAIT -> req 1 is served next and req 2 is not re-granted until req 1's done_o.
- Zero length: req_i=0100, len 0 -> done_o=0100 after 4 cycles, cksum_val_o=0xFFFF.
- Reset mid-job: rst asserted during WAIT -> grant_o, done_o and eng_start_o are 0 immediately (asynchronous); after release req_i=1000 is granted index 3 and completes normally.
- With CKSUM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, engine ready held low -> done_o pulses with err_o=1 and cksum_val_o=0, and the next request is serviced.
